// File: rtl/gate_test_pkg.sv
// Shared types and constants for the 3-input gate tester.
package gate_test_pkg;

  localparam int unsigned VEC_W   = 3;
  localparam int unsigned NUM_VEC = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned ERR_W   = 4;

  localparam logic [NUM_VEC-1:0] NAND3_TRUTH = 8'h7F;
  localparam logic [NUM_VEC-1:0] NOR3_TRUTH  = 8'h01;
  localparam logic [NUM_VEC-1:0] XOR3_TRUTH  = 8'h96;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic is_last_vec(input logic [VEC_W-1:0] v);
    return v == VEC_W'(NUM_VEC - 1);
  endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// Down-counter that holds a vector for a loaded number of clocks and flags the last one.
module gate_settle_timer
  import gate_test_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  // Final settle cycle: the counter is about to pass through 1.
  assign expire_c = en && (count == CNT_W'(1));

endmodule

// File: rtl/three_input_gate_tester.sv
// Sweeps all 8 a/b/c vectors into a 3-input gate, waits a settle time, and
// checks dut_d against an expected truth table.
module three_input_gate_tester
  import gate_test_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES = 2,
  parameter logic [NUM_VEC-1:0] GATE_TRUTH    = NAND3_TRUTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_c,
  input  logic             dut_d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
);

  state_t           state, state_n;
  logic [VEC_W-1:0] vec, vec_n;
  logic [VEC_W-1:0] drive_vec, drive_n;
  logic [ERR_W-1:0] err_n;
  logic [VEC_W-1:0] ffv_n;
  logic             fv_n, busy_n, done_n, pass_n;
  logic             timer_load, timer_en, expire_c, mismatch;

  gate_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (CNT_W'(SETTLE_CYCLES)),
    .expire_c (expire_c)
  );

  assign {dut_a, dut_b, dut_c} = drive_vec;

  // State and registered outputs; every output updates from its next value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      vec            <= '0;
      drive_vec      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      state          <= state_n;
      vec            <= vec_n;
      drive_vec      <= drive_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      err_count      <= err_n;
      fail_valid     <= fv_n;
      first_fail_vec <= ffv_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = DRIVE;
      DRIVE:   state_n = SETTLE;
      SETTLE:  if (expire_c) state_n = CHECK;
      CHECK:   state_n = is_last_vec(vec) ? DONE : DRIVE;
      DONE:    if (start) state_n = DRIVE;
      default: state_n = IDLE;
    endcase
  end

  // Result bookkeeping and next output values; the vec-7 mismatch lands with DONE.
  always_comb begin
    vec_n      = vec;
    err_n      = err_count;
    fv_n       = fail_valid;
    ffv_n      = first_fail_vec;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    mismatch   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          vec_n = '0;
          err_n = '0;
          fv_n  = 1'b0;
          ffv_n = '0;
        end
      end
      DRIVE:  timer_load = 1'b1;
      SETTLE: timer_en   = 1'b1;
      CHECK: begin
        mismatch = (dut_d != GATE_TRUTH[vec]);
        if (mismatch) begin
          err_n = err_count + ERR_W'(1);
          if (!fail_valid) begin
            fv_n  = 1'b1;
            ffv_n = vec;
          end
        end
        if (!is_last_vec(vec)) vec_n = vec + VEC_W'(1);
      end
      default: ;
    endcase
    busy_n  = (state_n == DRIVE) || (state_n == SETTLE) || (state_n == CHECK);
    done_n  = (state_n == DONE);
    pass_n  = done_n && (err_n == '0);
    drive_n = busy_n ? vec_n : '0;
  end

endmodule

// File: doc/three_input_gate_tester.md
Name: three_input_gate_tester

Overview:
- Self-checking stimulus/response engine for a 3-input combinational gate under test (DUT). It is the driving and checking end of the gate's a/b/c→d interface.
- On `start`, it sweeps all 8 input vectors and waits a programmable settle time after each. It then samples the DUT output and compares it against an expected truth table.
- It reports the error count, the first failing vector and a pass flag.
- Sits beside lab gate modules (NAND/NOR/XOR) on the board/top level, with results going to LEDs.

Parameters:
- SETTLE_CYCLES, 2, clocks the vector is held before sampling dut_d; legal range 1..15
- GATE_TRUTH, 8'h7F, expected dut_d per vector index; bit i = expected output for {a,b,c}=i (8'h7F = 3-input NAND)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level; sampled only in IDLE or DONE; begins a sweep
- dut_a  output  1  DUT input a (vector bit 2, MSB)
- dut_b  output  1  DUT input b (vector bit 1)
- dut_c  output  1  DUT input c (vector bit 0)
- dut_d  input  1  DUT output under test
- busy  output  1  high from the sweep start until DONE is entered
- done  output  1  high in DONE, held until next start or reset
- pass  output  1  valid when done=1; 1 iff err_count==0
- err_count  output  4  number of mismatching vectors, range 0..8
- fail_valid  output  1  at least one mismatch recorded this sweep
- first_fail_vec  output  3  index of the lowest failing vector; 0 when fail_valid=0

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - rst_n is asynchronous assert, synchronous deassert at the board level.
  - On reset, all outputs go to 0 immediately, state=IDLE, vector index=0.
- States:
  - IDLE: dut_{a,b,c}=000; start=1 → DRIVE with vec=0, clear err_count, fail_valid and first_fail_vec; busy=1.
  - DRIVE: one cycle; {dut_a,dut_b,dut_c}=vec (registered outputs); load settle counter=SETTLE_CYCLES; → SETTLE.
  - SETTLE: vector held; decrement counter; at count 1 → CHECK.
  - CHECK: one cycle; compare dut_d with GATE_TRUTH[vec].
    - On mismatch: err_count+1. If fail_valid=0, capture first_fail_vec=vec and set fail_valid.
    - If vec==7 → DONE; otherwise vec+1 → DRIVE.
  - DONE: dut_{a,b,c}=000, busy=0, done=1, pass=(err_count==0); start=1 → same action as from IDLE (done drops the next cycle).
- Timing:
  - Each vector occupies SETTLE_CYCLES+2 clocks.
  - With start sampled at edge 0, done rises at edge 8*(SETTLE_CYCLES+2). Default: edge 32.
- Inputs:
  - dut_d is sampled only in CHECK and ignored in all other states.
  - start is ignored while busy=1; a level held high in DONE retriggers immediately.
- Counts: err_count cannot exceed 8, so no saturation logic is needed. The 4-bit width covers 8.
- Vector index: vec is a 3-bit counter. Wrap from 7 is never taken because CHECK of vec 7 exits to DONE.
- Reset mid-sweep: outputs clear at once and the tester returns to IDLE. No partial results are retained.
- Simultaneous events: a mismatch at vec 7 and the DONE transition happen in the same edge. The count must include vec 7 before done/pass become visible.

Decomposition:
- Shared package (gate_test_pkg):
  - state enum (IDLE, DRIVE, SETTLE, CHECK, DONE)
  - VEC_W=3, NUM_VEC=8
  - truth constants NAND3_TRUTH=8'h7F, NOR3_TRUTH=8'h01, XOR3_TRUTH=8'h96
- Sub-module gate_settle_timer: 4-bit down-counter with load and expire pulse, used by SETTLE.

Test Plan:
- Real 3-input NAND as DUT, start pulse → busy high for edges 1..31, done at edge 32, pass=1, err_count=0, fail_valid=0; dut vectors observed 000..111 in order.
- dut_d stuck at 1 → err_count=1, fail_valid=1, first_fail_vec=7, pass=0.
- dut_d stuck at 0 → err_count=7, first_fail_vec=0; AND gate as DUT → err_count=8, first_fail_vec=0.
- start pulsed at edges 5 and 20 during a sweep → ignored, done still at edge 32; start again in DONE → counters clear, second sweep completes at +32.
- rst_n low at edge 13 → all outputs 0 asynchronously, state IDLE; fresh start gives a correct full sweep.
- SETTLE_CYCLES=1 with GATE_TRUTH=XOR3_TRUTH and an XOR DUT → done at edge 24, pass=1.
